mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, next to the ALU. It takes the same forwarded operands as the ALU and shifter. Its result joins the ALU result in the EX result mux that feeds the EX/MEM register. While an operation is in flight it requests a pipeline stall from the hazard unit. It uses one radix-2 iteration per cycle (shift-add for multiply, restoring for divide).

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_sign_fix.sv | 36 +++
 rtl/mdu_iter.sv | 163 ++++++++++++++++
 tb/tb_mdu_iter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the M-extension funct3 codes, FSM encoding and iteration count.
// Also holds small helpers that decode operand signedness from funct3.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_MULHSU) ||
           (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and output selection for the multiply/divide unit.
// Latency: purely combinational.
// Backpressure: none; the FSM samples the output only in its FIX state.
module mdu_sign_fix
  import mdu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] work,
  input  logic        neg_main,
  input  logic        neg_rem,
  output logic [31:0] result
);

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  // work holds the unsigned product, or {remainder, quotient} for divides
  always_comb begin
    prod = neg_main ? -work : work;
    quo  = neg_main ? -work[31:0] : work[31:0];
    rem  = neg_rem ? -work[63:32] : work[63:32];
    case (funct3)
      MDU_MUL:    result = prod[31:0];
      MDU_MULH:   result = prod[63:32];
      MDU_MULHSU: result = prod[63:32];
      MDU_MULHU:  result = prod[63:32];
      MDU_DIV:    result = quo;
      MDU_DIVU:   result = quo;
      MDU_REM:    result = rem;
      MDU_REMU:   result = rem;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Latency: 35 cycles from accepted start to done, 2 cycles for divide special cases.
// Backpressure: stall is raised from acceptance until the DONE cycle; flush aborts silently.
module mdu_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] LAST_ITER = 5'(MDU_ITER - 1);

  mdu_state_t  state;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] mag;
  logic [63:0] work;
  logic [4:0]  count;
  logic        neg_main;
  logic        neg_rem;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] special_res;
  logic [63:0] work_nxt;
  logic [32:0] sum;
  logic [32:0] r_shift;
  logic [32:0] diff;
  logic [31:0] fix_result;

  // operand magnitudes, result signs and divide special cases, used in PREP
  always_comb begin
    a_neg    = a_is_signed(op) & opa[31];
    b_neg    = b_is_signed(op) & opb[31];
    mag_a    = a_neg ? -opa : opa;
    mag_b    = b_neg ? -opb : opb;
    div_zero = op[2] & (opb == 32'h0);
    div_ovf  = op[2] & ~op[0] & (opa == 32'h8000_0000) & (opb == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_res = op[1] ? opa : 32'hFFFF_FFFF;
    end else begin
      special_res = op[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // one shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    sum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, mag} : 33'h0);
    r_shift = {work[63:32], work[31]};
    diff    = r_shift - {1'b0, mag};
    if (op[2]) begin
      if (!diff[32]) begin
        work_nxt = {diff[31:0], work[30:0], 1'b1};
      end else begin
        work_nxt = {r_shift[31:0], work[30:0], 1'b0};
      end
    end else begin
      work_nxt = {sum, work[31:1]};
    end
  end

  mdu_sign_fix u_sign_fix (
    .funct3   (op),
    .work     (work),
    .neg_main (neg_main),
    .neg_rem  (neg_rem),
    .result   (fix_result)
  );

  // hold the pipeline while a request is being accepted or is in flight
  assign stall = (start & (state == ST_IDLE) & ~flush) |
                 ((state != ST_IDLE) & (state != ST_DONE));

  // control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op       <= '0;
      opa      <= '0;
      opb      <= '0;
      mag      <= '0;
      work     <= '0;
      count    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op    <= funct3;
            opa   <= a;
            opb   <= b;
            state <= ST_PREP;
            busy  <= 1'b1;
          end
        end
        ST_PREP: begin
          neg_main <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          count    <= '0;
          if (div_zero || div_ovf) begin
            result <= special_res;
            state  <= ST_DONE;
            done   <= 1'b1;
          end else begin
            state <= ST_CALC;
            if (op[2]) begin
              mag  <= mag_b;
              work <= {32'h0, mag_a};
            end else begin
              mag  <= mag_a;
              work <= {32'h0, mag_b};
            end
          end
        end
        ST_CALC: begin
          work  <= work_nxt;
          count <= count + 5'd1;
          if (count == LAST_ITER) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result <= fix_result;
          state  <= ST_DONE;
          done   <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases, flush/reset scenarios, random ops.
// Expected results come from a 64-bit arithmetic model of the RV32M rules.
// All outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          failures;
  logic [31:0] last_exp;
  string       cur;

  mdu_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard stop in case something unforeseen blocks the sequence
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s [%s] observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  // architectural RV32M result computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] x,
                                          input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      ux;
    longint      uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    p  = '0;
    case (f)
      MDU_MUL:    p = sx * sy;
      MDU_MULH:   p = (sx * sy) >> 32;
      MDU_MULHSU: p = (sx * uy) >> 32;
      MDU_MULHU:  p = (ux * uy) >> 32;
      MDU_DIV: begin
        if (y == 0) p = 64'hFFFF_FFFF;
        else p = sx / sy;
      end
      MDU_DIVU: begin
        if (y == 0) p = 64'hFFFF_FFFF;
        else p = ux / uy;
      end
      MDU_REM: begin
        if (y == 0) p = ux;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = 0;
        else p = sx % sy;
      end
      MDU_REMU: begin
        if (y == 0) p = ux;
        else p = ux % uy;
      end
      default: p = '0;
    endcase
    return p[31:0];
  endfunction

  // cycles from acceptance to done: divide-by-zero and signed overflow short-circuit
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 2;
    if ((f == MDU_DIV || f == MDU_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // issue one operation and check stall/busy/done/result in every cycle until IDLE
  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input bit pulse_busy);
    logic [31:0] exp;
    int          lat;
    exp = ref_mdu(f, x, y);
    lat = ref_lat(f, x, y);
    cur = $sformatf("f=%0d a=%h b=%h", f, x, y);
    @(posedge clk);
    #1;
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(negedge clk);
    chk("stall_c0", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k < lat) begin
        chk("done_busy", {31'h0, done}, 32'h0);
        chk("stall_busy", {31'h0, stall}, 32'h1);
        chk("busy_busy", {31'h0, busy}, 32'h1);
      end else if (k == lat) begin
        chk("done_pulse", {31'h0, done}, 32'h1);
        chk("stall_done", {31'h0, stall}, 32'h0);
        chk("result", result, exp);
      end else begin
        chk("done_after", {31'h0, done}, 32'h0);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk("result_held", result, exp);
      end
      @(posedge clk);
      #1;
      start  = (pulse_busy && (k + 1 <= lat)) ? 1'($urandom_range(0, 1)) : 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      a      = $urandom;
      b      = $urandom;
    end
    start    = 1'b0;
    last_exp = exp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur      = "reset";
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'h0;
    a        = 32'h0;
    b        = 32'h0;
    last_exp = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_result", result, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed multiplies and divides
    do_op(MDU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    chk("mul_neg_const", last_exp, 32'hFFFF_FFEB);
    do_op(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(MDU_DIVU,   32'd100, 32'd7, 1'b0);
    do_op(MDU_REMU,   32'd100, 32'd7, 1'b0);

    // special cases resolved early
    do_op(MDU_DIVU,   32'd5, 32'd0, 1'b0);
    do_op(MDU_REM,    32'd5, 32'd0, 1'b0);
    do_op(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // flush in cycle 10 of a DIV: silent abort, result unchanged
    do_op(MDU_MUL, 32'd6, 32'd9, 1'b0);
    cur = "flush DIV 100/-7";
    @(posedge clk);
    #1;
    funct3 = MDU_DIV;
    a      = 32'd100;
    b      = 32'hFFFF_FFF9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_c10_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int k = 11; k <= 40; k++) begin
      @(negedge clk);
      chk("flush_busy", {31'h0, busy}, 32'h0);
      chk("flush_done", {31'h0, done}, 32'h0);
      chk("flush_result", result, last_exp);
      @(posedge clk);
      #1;
    end

    // flush and start together in IDLE: nothing accepted
    cur    = "flush+start";
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = MDU_MUL;
    a      = 32'd2;
    b      = 32'd2;
    @(negedge clk);
    chk("fs_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fs_busy", {31'h0, busy}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("fs_done", {31'h0, done}, 32'h0);
    end
    chk("fs_result", result, last_exp);

    // reset asserted in cycle 20 of a MUL
    cur = "reset mid MUL";
    @(posedge clk);
    #1;
    funct3 = MDU_MUL;
    a      = 32'h1234_5678;
    b      = 32'h9ABC_DEF0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_result", result, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op(MDU_MUL, 32'd3, 32'd4, 1'b1);
    chk("mul_3x4_const", last_exp, 32'd12);

    // randomized operations, with ignored start pulses while busy
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
